// File: rtl/booth_mult_ctrl_if.sv
// Operand/product handshake bundle for booth_mult_ctrl.
// The master side is the operand source and result consumer; the slave side is the sequencer.
interface booth_mult_ctrl_if #(
  parameter int WIDTH = 64
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               out_err;
  logic               busy;

  modport master (
    output in_valid, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product, out_err, busy
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product, out_err, busy
  );
endinterface

// File: rtl/booth_mult_ctrl.sv
// Signed 64x64 radix-2 Booth multiplier sequencer; BOOTH_STEP2_EN chains two substeps per cycle.
// Latency: accept edge k -> out_valid after edge k+64 (k+32 with BOOTH_STEP2_EN).
// Backpressure: in_ready only in IDLE; product held in DONE until out_ready.
module booth_mult_ctrl #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input logic              clk,
  input logic              rst_n,
  booth_mult_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef BOOTH_STEP2_EN
  localparam logic [CNT_W-1:0] STEP = CNT_W'(2);
`else
  localparam logic [CNT_W-1:0] STEP = CNT_W'(1);
`endif
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] M_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             q0_q, q0_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] s0_acc, s0_q;
  logic             s0_q0;
  logic [WIDTH-1:0] step_acc, step_q;
  logic             step_q0;

  booth_substep u_step0 (
    .acc_i      (acc_q),
    .q_i        (q_q),
    .q0_i       (q0_q),
    .m_i        (m_q),
    .next_acc_o (s0_acc),
    .next_q_o   (s0_q),
    .q0_next_o  (s0_q0)
  );

`ifdef BOOTH_STEP2_EN
  booth_substep u_step1 (
    .acc_i      (s0_acc),
    .q_i        (s0_q),
    .q0_i       (s0_q0),
    .m_i        (m_q),
    .next_acc_o (step_acc),
    .next_q_o   (step_q),
    .q0_next_o  (step_q0)
  );
`else
  assign step_acc = s0_acc;
  assign step_q   = s0_q;
  assign step_q0  = s0_q0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      q0_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      q0_q    <= q0_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    m_d     = m_q;
    q0_d    = q0_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d   = '0;
          q_d     = bus.multiplier;
          q0_d    = 1'b0;
          m_d     = bus.multiplicand;
          cnt_d   = '0;
          // acc - M can overflow for the most negative multiplicand
          err_d   = (bus.multiplicand == M_MIN);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_acc;
        q_d   = step_q;
        q0_d  = step_q0;
        cnt_d = cnt_q + STEP;
        if (cnt_d == LAST) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.product   = {acc_q, q_q};
  assign bus.out_err   = err_q;
endmodule

// One radix-2 Booth step on {acc,Q,q0}: conditional add/subtract of M, then arithmetic shift right.
module booth_substep (
  input  logic [63:0] acc_i,
  input  logic [63:0] q_i,
  input  logic        q0_i,
  input  logic [63:0] m_i,
  output logic [63:0] next_acc_o,
  output logic [63:0] next_q_o,
  output logic        q0_next_o
);
  logic [63:0] sum;

  always_comb begin
    sum = acc_i;
    case ({q_i[0], q0_i})
      2'b10:   sum = acc_i - m_i;
      2'b01:   sum = acc_i + m_i;
      default: sum = acc_i;
    endcase
  end

  assign next_acc_o = {sum[63], sum[63:1]};
  assign next_q_o   = {sum[0], q_i[63:1]};
  assign q0_next_o  = q_i[0];
endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Self-checking bench for booth_mult_ctrl: directed corner cases plus random operands
// compared against a plain 128-bit signed multiply.
module tb_booth_mult_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  booth_mult_ctrl_if bus ();

  booth_mult_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef BOOTH_STEP2_EN
  localparam int LAT = 32;
`else
  localparam int LAT = 64;
`endif
  localparam logic [63:0] M_MIN = 64'h8000_0000_0000_0000;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(input logic [63:0] m, input logic [63:0] q);
    logic signed [127:0] a;
    logic signed [127:0] b;
    a = {{64{m[63]}}, m};
    b = {{64{q[63]}}, q};
    return a * b;
  endfunction

  // Issue one operand pair, time the result, optionally stall the consumer, then retire it.
  task automatic run_op(input string tag, input logic [63:0] m, input logic [63:0] q,
                        input int hold, input bit chk_prod);
    int cyc;
    logic [127:0] exp;
    exp = ref_mul(m, q);
    check({tag, "/idle_in_ready"}, 128'(bus.in_ready), 128'(1));
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.in_valid     = 1'b1;
    bus.out_ready    = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid     = 1'b0;
    bus.multiplicand = ~m;
    bus.multiplier   = ~q;
    check({tag, "/run_busy"}, 128'(bus.busy), 128'(1));
    check({tag, "/run_in_ready"}, 128'(bus.in_ready), 128'(0));
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "/latency"}, 128'(cyc), 128'(LAT));
    if (chk_prod) check({tag, "/product"}, bus.product, exp);
    check({tag, "/out_err"}, 128'(bus.out_err), 128'(m == M_MIN));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, "/hold_out_valid"}, 128'(bus.out_valid), 128'(1));
      check({tag, "/hold_in_ready"}, 128'(bus.in_ready), 128'(0));
      if (chk_prod) check({tag, "/hold_product"}, bus.product, exp);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "/ret_out_valid"}, 128'(bus.out_valid), 128'(0));
    check({tag, "/ret_in_ready"}, 128'(bus.in_ready), 128'(1));
    check({tag, "/ret_busy"}, 128'(bus.busy), 128'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] rm;
    logic [63:0] rq;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst/in_ready", 128'(bus.in_ready), 128'(1));
    check("rst/out_valid", 128'(bus.out_valid), 128'(0));
    check("rst/busy", 128'(bus.busy), 128'(0));
    check("rst/product", bus.product, 128'(0));
    check("rst/out_err", 128'(bus.out_err), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("3x5", 64'd3, 64'd5, 0, 1'b1);
    check("3x5/value", bus.product, 128'd15);
    run_op("m7x6", -64'sd7, 64'd6, 0, 1'b1);
    run_op("2xmin", 64'd2, M_MIN, 1, 1'b1);
    run_op("minx1", M_MIN, 64'd1, 0, 1'b0);
    run_op("hold10", 64'd123456789, -64'sd987654321, 10, 1'b1);
    run_op("0x0", 64'd0, 64'd0, 0, 1'b1);
    run_op("maxxmax", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 2, 1'b1);
    run_op("m1xmin", -64'sd1, M_MIN, 0, 1'b1);

    // Reset in the middle of a run discards the partial result
    bus.multiplicand = 64'd7;
    bus.multiplier   = 64'd9;
    bus.in_valid     = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst/out_valid", 128'(bus.out_valid), 128'(0));
    check("midrst/in_ready", 128'(bus.in_ready), 128'(1));
    check("midrst/busy", 128'(bus.busy), 128'(0));
    check("midrst/product", bus.product, 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("4xm4", 64'd4, -64'sd4, 0, 1'b1);
    check("4xm4/value", bus.product, {{64{1'b1}}, -64'sd16});

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        rm = 64'(longint'(int'($urandom_range(0, 200)) - 100));
        rq = 64'(longint'(int'($urandom_range(0, 200)) - 100));
      end else begin
        rm = {$urandom, $urandom};
        rq = {$urandom, $urandom};
      end
      if (rm == M_MIN) rm = 64'd1;
      run_op($sformatf("rnd%0d", n), rm, rq, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
